// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: arbiter state encodings and cache line geometry shared with the qspi engine and caches.
package qspi_arb_pkg;

    typedef enum logic [2:0] {
        QA_IDLE   = 3'd0,
        QA_I_FILL = 3'd1,
        QA_D_PUSH = 3'd2,
        QA_D_PULL = 3'd3,
        QA_GAP    = 3'd4
    } qa_state_e;

    function automatic int lw_of(input int line_length);
        return $clog2(line_length);
    endfunction

endpackage

// File: rtl/qspi_arb_rr.sv
// qspi_arb_rr: two-requester round-robin picker; the side not served last wins a tie.
module qspi_arb_rr (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic grant_d,
    output logic grant_any
);

    assign grant_any = i_req | d_req;
    assign grant_d   = d_req & (!i_req | !last_d);

endmodule

// File: rtl/qspi_arb.sv
// qspi_arb: serialises icache refills and dcache push/pull onto the single QSPI line engine,
// with round-robin fairness and a chip-select turnaround gap between transfers.
module qspi_arb
    import qspi_arb_pkg::*;
#(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int GAP         = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_pull,
    input  logic [PA-lw_of(LINE_LENGTH)-1:0] i_tag,
    input  logic                             d_push,
    input  logic                             d_pull,
    input  logic [PA-lw_of(LINE_LENGTH)-1:0] d_tag,
    input  logic                             rom_enable,
    input  logic                             io_access,
    input  logic                             fault,
    input  logic                             q_done,
    output logic                             q_req,
    output logic                             q_i_d,
    output logic                             q_write,
    output logic                             q_mem,
    output logic [PA-lw_of(LINE_LENGTH)-1:0] q_paddr,
    output logic                             i_done,
    output logic                             d_done,
    output logic                             busy
);

    qa_state_e  state, state_n;
    logic [3:0] cnt;
    logic       last_d, pull_pending;
    logic       grant_d, grant_any, start;

    qspi_arb_rr u_rr (
        .i_req    (i_pull & !fault),
        .d_req    ((d_push | d_pull) & !fault & !io_access),
        .last_d   (last_d),
        .grant_d  (grant_d),
        .grant_any(grant_any)
    );

    always_comb begin
        state_n = state;
        case (state)
            QA_IDLE:
                if (grant_any) state_n = grant_d ? (d_push ? QA_D_PUSH : QA_D_PULL) : QA_I_FILL;
            QA_I_FILL, QA_D_PULL:
                if (q_done) state_n = GAP > 0 ? QA_GAP : QA_IDLE;
            QA_D_PUSH:
                if (q_done) state_n = GAP > 0 ? QA_GAP : QA_D_PULL;
            QA_GAP:
                if (cnt == 4'd0) state_n = pull_pending ? QA_D_PULL : QA_IDLE;
            default:
                state_n = QA_IDLE;
        endcase
    end

    // Tag and flags are captured on every entry into a transfer, including the pull after a push.
    assign start = state_n != state && state_n inside {QA_I_FILL, QA_D_PUSH, QA_D_PULL};
    assign q_req = state inside {QA_I_FILL, QA_D_PUSH, QA_D_PULL};
    assign busy  = state != QA_IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= QA_IDLE;
            cnt          <= 4'd0;
            last_d       <= 1'b0;
            pull_pending <= 1'b0;
            q_i_d        <= 1'b0;
            q_write      <= 1'b0;
            q_mem        <= 1'b0;
            q_paddr      <= '0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
        end else begin
            state        <= state_n;
            i_done       <= state == QA_I_FILL && q_done;
            d_done       <= (state == QA_D_PUSH || state == QA_D_PULL) && q_done;
            cnt          <= (state_n == QA_GAP && state != QA_GAP) ? 4'(GAP - 1) : (cnt != 4'd0 ? cnt - 4'd1 : 4'd0);
            pull_pending <= state_n == QA_GAP && (state == QA_D_PUSH || pull_pending);
            if (state == QA_IDLE && grant_any) last_d <= grant_d;
            if (start) begin
                q_paddr <= state_n == QA_I_FILL ? i_tag : d_tag;
                q_i_d   <= state_n == QA_I_FILL;
                q_write <= state_n == QA_D_PUSH;
                q_mem   <= rom_enable & (state_n != QA_D_PUSH);
            end
        end
    end

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_qspi_arb;

    localparam int G0 = 2;

    logic        clk = 0, reset = 0;
    logic        i_pull = 0, d_push = 0, d_pull = 0, rom_enable = 0, io_access = 0, fault = 0;
    logic [19:0] i_tag = 0, d_tag = 0, new_tag = 0;
    logic        mdone0 = 0, mdone1 = 0, auto_done = 0, resp_en = 0;
    wire         q_done0 = resp_en ? auto_done : mdone0;
    logic        q_req0, q_i_d0, q_write0, q_mem0, i_done0, d_done0, busy0;
    logic        q_req1, q_i_d1, q_write1, q_mem1, i_done1, d_done1, busy1;
    logic [19:0] q_paddr0, q_paddr1;
    int          tests = 0, fails = 0, rcnt = 0, resp_lat = 0;

    always #5 clk = ~clk;

    qspi_arb #(.PA(22), .LINE_LENGTH(4), .GAP(G0)) u0 (
        .clk(clk), .reset(reset), .i_pull(i_pull), .i_tag(i_tag), .d_push(d_push), .d_pull(d_pull),
        .d_tag(d_tag), .rom_enable(rom_enable), .io_access(io_access), .fault(fault), .q_done(q_done0),
        .q_req(q_req0), .q_i_d(q_i_d0), .q_write(q_write0), .q_mem(q_mem0), .q_paddr(q_paddr0),
        .i_done(i_done0), .d_done(d_done0), .busy(busy0));

    qspi_arb #(.PA(22), .LINE_LENGTH(4), .GAP(0)) u1 (
        .clk(clk), .reset(reset), .i_pull(i_pull), .i_tag(i_tag), .d_push(d_push), .d_pull(d_pull),
        .d_tag(d_tag), .rom_enable(rom_enable), .io_access(io_access), .fault(fault), .q_done(mdone1),
        .q_req(q_req1), .q_i_d(q_i_d1), .q_write(q_write1), .q_mem(q_mem1), .q_paddr(q_paddr1),
        .i_done(i_done1), .d_done(d_done1), .busy(busy1));

    // QSPI stand-in for u0: completes each transfer a random number of cycles after q_req.
    always @(negedge clk) begin
        if (q_req0 && !auto_done) begin
            if (rcnt >= resp_lat) begin
                auto_done = 1;
                rcnt = 0;
                resp_lat = $urandom_range(0, 4);
            end else rcnt++;
        end else auto_done = 0;
    end

    // Reference model for u0 (GAP=G0): phase 0 idle, 1 transfer, 2 turnaround; kind 0 icache, 1 push, 2 pull.
    int   m_phase, m_kind, m_gap;
    bit   m_owe, m_last_d, m_ci, m_cd, m_fin, m_take_d;
    bit   e_i_done, e_d_done, e_i_d, e_write, e_mem;
    logic [19:0] e_tag;

    task automatic m_start(input int k);
        m_phase = 1;
        m_kind  = k;
        e_tag   = k == 0 ? i_tag : d_tag;
        e_i_d   = k == 0;
        e_write = k == 1;
        e_mem   = rom_enable && k != 1;
    endtask

    task automatic m_after;
        if (m_owe) begin
            m_owe = 0;
            m_start(2);
        end else m_phase = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_kind = 0; m_gap = 0; m_owe = 0; m_last_d = 0;
            e_i_done = 0; e_d_done = 0; e_i_d = 0; e_write = 0; e_mem = 0; e_tag = 0;
        end else begin
            m_fin    = m_phase == 1 && q_done0;
            e_i_done = m_fin && m_kind == 0;
            e_d_done = m_fin && m_kind != 0;
            m_ci     = i_pull && !fault;
            m_cd     = (d_push || d_pull) && !fault && !io_access;
            if (m_phase == 0) begin
                if (m_ci || m_cd) begin
                    m_take_d = m_cd && !(m_ci && m_last_d);
                    m_last_d = m_take_d;
                    m_start(m_take_d ? (d_push ? 1 : 2) : 0);
                end
            end else if (m_phase == 1) begin
                if (m_fin) begin
                    if (m_kind == 1) m_owe = 1;
                    if (G0 == 0) m_after();
                    else begin
                        m_phase = 2;
                        m_gap   = G0;
                    end
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_after();
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        {i_pull, d_push, d_pull, rom_enable, io_access, fault, mdone0, mdone1, resp_en} = '0;
        reset = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 0;
        #1;
        tests++;
        if ({q_req0, q_i_d0, q_write0, q_mem0, i_done0, d_done0, busy0} !== 7'b0 || q_paddr0 !== 20'h0) begin
            fails++;
            $display("FAIL reset_values: flags=%b paddr=%h, want all zero", {q_req0, q_i_d0, q_write0, q_mem0, i_done0, d_done0, busy0}, q_paddr0);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || q_req0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b q_req=%b, want 0 0", busy0, q_req0);
        end
    endtask

    task automatic test_icache_fill;
        do_reset();
        i_tag = 20'h12345;
        i_pull = 1;
        @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || q_i_d0 !== 1'b1 || q_write0 !== 1'b0 || q_paddr0 !== 20'h12345) begin
            fails++;
            $display("FAIL ifill_grant: req=%b i_d=%b wr=%b paddr=%h, want 1 1 0 12345", q_req0, q_i_d0, q_write0, q_paddr0);
        end
        repeat (7) @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || i_done0 !== 1'b0) begin
            fails++;
            $display("FAIL ifill_hold: req=%b i_done=%b, want 1 0", q_req0, i_done0);
        end
        mdone0 = 1;
        @(negedge clk);
        mdone0 = 0;
        i_pull = 0;
        tests++;
        if (i_done0 !== 1'b1 || q_req0 !== 1'b0 || d_done0 !== 1'b0) begin
            fails++;
            $display("FAIL ifill_done: i_done=%b req=%b d_done=%b, want 1 0 0", i_done0, q_req0, d_done0);
        end
        @(negedge clk);
        tests++;
        if (i_done0 !== 1'b0 || q_req0 !== 1'b0 || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL ifill_gap: i_done=%b req=%b busy=%b, want 0 0 1", i_done0, q_req0, busy0);
        end
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0) begin
            fails++;
            $display("FAIL ifill_idle: busy=%b, want 0", busy0);
        end
    endtask

    task automatic test_push_pull;
        do_reset();
        d_tag = 20'h00100;
        d_push = 1;
        d_pull = 1;
        rom_enable = 1;
        @(negedge clk);
        i_tag = 20'h00abc;
        i_pull = 1;
        tests++;
        if (q_req0 !== 1'b1 || q_write0 !== 1'b1 || q_i_d0 !== 1'b0 || q_mem0 !== 1'b0 || q_paddr0 !== 20'h00100) begin
            fails++;
            $display("FAIL push_grant: req=%b wr=%b i_d=%b mem=%b paddr=%h, want 1 1 0 0 00100", q_req0, q_write0, q_i_d0, q_mem0, q_paddr0);
        end
        repeat (2) @(negedge clk);
        mdone0 = 1;
        @(negedge clk);
        mdone0 = 0;
        tests++;
        if (d_done0 !== 1'b1 || q_req0 !== 1'b0) begin
            fails++;
            $display("FAIL push_done: d_done=%b req=%b, want 1 0", d_done0, q_req0);
        end
        d_push = 0;
        d_tag = 20'h00200;
        @(negedge clk);
        tests++;
        if (q_req0 !== 1'b0 || d_done0 !== 1'b0) begin
            fails++;
            $display("FAIL push_gap: req=%b d_done=%b, want 0 0", q_req0, d_done0);
        end
        @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || q_write0 !== 1'b0 || q_i_d0 !== 1'b0 || q_mem0 !== 1'b1 || q_paddr0 !== 20'h00200) begin
            fails++;
            $display("FAIL pull_grant: req=%b wr=%b i_d=%b mem=%b paddr=%h, want 1 0 0 1 00200", q_req0, q_write0, q_i_d0, q_mem0, q_paddr0);
        end
        mdone0 = 1;
        @(negedge clk);
        mdone0 = 0;
        d_pull = 0;
        tests++;
        if (d_done0 !== 1'b1) begin
            fails++;
            $display("FAIL pull_done: d_done=%b, want 1", d_done0);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || q_i_d0 !== 1'b1 || q_paddr0 !== 20'h00abc) begin
            fails++;
            $display("FAIL ifill_after_pull: req=%b i_d=%b paddr=%h, want 1 1 00abc", q_req0, q_i_d0, q_paddr0);
        end
    endtask

    task automatic test_alternate;
        int  n = 0;
        bit  prev = 0;
        do_reset();
        resp_en = 1;
        i_pull = 1;
        d_pull = 1;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clk);
            if (q_req0 && !prev) begin
                tests++;
                if (q_i_d0 !== 1'(n % 2)) begin
                    fails++;
                    $display("FAIL alternate_grant%0d: i_d=%b, want %b", n, q_i_d0, 1'(n % 2));
                end
                n++;
            end
            prev = q_req0;
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL alternate_timeout: saw %0d grants, want 4", n);
        end
    endtask

    task automatic test_blocking;
        do_reset();
        fault = 1;
        i_pull = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (q_req0 !== 1'b0) begin
                fails++;
                $display("FAIL fault_block: req=%b, want 0", q_req0);
            end
        end
        fault = 0;
        @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || q_i_d0 !== 1'b1) begin
            fails++;
            $display("FAIL fault_release: req=%b i_d=%b, want 1 1", q_req0, q_i_d0);
        end
        mdone0 = 1;
        @(negedge clk);
        mdone0 = 0;
        i_pull = 0;
        repeat (3) @(negedge clk);
        io_access = 1;
        d_pull = 1;
        repeat (3) @(negedge clk);
        tests++;
        if (q_req0 !== 1'b0) begin
            fails++;
            $display("FAIL io_block: req=%b, want 0", q_req0);
        end
        i_pull = 1;
        @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || q_i_d0 !== 1'b1) begin
            fails++;
            $display("FAIL io_icache: req=%b i_d=%b, want 1 1", q_req0, q_i_d0);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        d_tag = 20'h00155;
        d_push = 1;
        d_pull = 1;
        @(negedge clk);
        tests++;
        if (q_req0 !== 1'b1 || q_write0 !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: req=%b wr=%b, want 1 1", q_req0, q_write0);
        end
        #2;
        reset = 0;
        #1;
        tests++;
        if ({q_req0, q_i_d0, q_write0, q_mem0, i_done0, d_done0, busy0} !== 7'b0 || q_paddr0 !== 20'h0) begin
            fails++;
            $display("FAIL midreset_async: flags=%b paddr=%h, want all zero", {q_req0, q_i_d0, q_write0, q_mem0, i_done0, d_done0, busy0}, q_paddr0);
        end
        @(negedge clk);
        d_push = 0;
        d_pull = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy0 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: busy=%b, want 0", busy0);
        end
        mdone0 = 1;
        @(negedge clk);
        mdone0 = 0;
        tests++;
        if (i_done0 !== 1'b0 || d_done0 !== 1'b0 || busy0 !== 1'b0) begin
            fails++;
            $display("FAIL stray_done: i_done=%b d_done=%b busy=%b, want 0 0 0", i_done0, d_done0, busy0);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        rom_enable = 1;
        i_tag = 20'($urandom);
        i_pull = 1;
        @(negedge clk);
        tests++;
        if (q_req1 !== 1'b1 || q_i_d1 !== 1'b1 || q_write1 !== 1'b0 || q_mem1 !== 1'b1 || q_paddr1 !== i_tag || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL gap0_grant: req=%b i_d=%b wr=%b mem=%b paddr=%h busy=%b, want 1 1 0 1 %h 1", q_req1, q_i_d1, q_write1, q_mem1, q_paddr1, busy1, i_tag);
        end
        mdone1 = 1;
        @(negedge clk);
        mdone1 = 0;
        tests++;
        if (q_req1 !== 1'b0 || i_done1 !== 1'b1 || d_done1 !== 1'b0) begin
            fails++;
            $display("FAIL gap0_done: req=%b i_done=%b d_done=%b, want 0 1 0", q_req1, i_done1, d_done1);
        end
        @(negedge clk);
        tests++;
        if (q_req1 !== 1'b1) begin
            fails++;
            $display("FAIL gap0_back_to_back: req=%b, want 1", q_req1);
        end
        i_pull = 0;
    endtask

    task automatic test_random;
        int shown = 0;
        do_reset();
        resp_en = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tests++;
            if (q_req0 !== (m_phase == 1) || busy0 !== (m_phase != 0) || i_done0 !== e_i_done || d_done0 !== e_d_done ||
                (m_phase == 1 && (q_i_d0 !== e_i_d || q_write0 !== e_write || q_mem0 !== e_mem || q_paddr0 !== e_tag))) begin
                fails++;
                if (shown++ < 20)
                    $display("FAIL random_c%0d: req=%b busy=%b idn=%b ddn=%b i_d=%b wr=%b mem=%b pa=%h, want %b %b %b %b %b %b %b %h",
                             c, q_req0, busy0, i_done0, d_done0, q_i_d0, q_write0, q_mem0, q_paddr0,
                             m_phase == 1, m_phase != 0, e_i_done, e_d_done, e_i_d, e_write, e_mem, e_tag);
            end
            if (i_pull && i_done0) i_pull = 0;
            else if (!i_pull && $urandom_range(0, 3) == 0) begin
                i_pull = 1;
                i_tag = 20'($urandom);
            end
            if (d_pull && d_done0) begin
                if (d_push) begin
                    d_push = 0;
                    d_tag = new_tag;
                end else d_pull = 0;
            end else if (!d_pull && $urandom_range(0, 3) == 0) begin
                d_pull = 1;
                d_push = 1'($urandom_range(0, 1));
                d_tag = 20'($urandom);
                new_tag = 20'($urandom);
            end
            fault = $urandom_range(0, 7) == 0;
            io_access = $urandom_range(0, 5) == 0;
            rom_enable = 1'($urandom);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1;
        test_reset();
        test_icache_fill();
        test_push_pull();
        test_alternate();
        test_blocking();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qspi_arb.md
# qspi_arb

Sequencing arbiter between the instruction cache, the data cache and the single QSPI line-transfer engine. Accepts icache refill requests and dcache writeback/refill requests, serialises them with round-robin fairness, and orders each dcache miss as push-then-pull. Drives the QSPI request, direction, write flag, memory select and line tag. Enforces a programmable chip-select turnaround gap between transfers.

## Interface
Parameters:
- PA, 22, physical address width
- LINE_LENGTH, 4, cache line bytes; LW = $clog2(LINE_LENGTH)
- GAP, 2, idle cycles forced between consecutive transfers (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- i_pull  in  1  icache line miss, level, held until i_done
- i_tag  in  PA-LW  icache line tag
- d_push  in  1  dcache dirty victim must be written, level
- d_pull  in  1  dcache line must be read, level
- d_tag  in  PA-LW  dcache tag (victim tag while d_push, new tag otherwise)
- rom_enable  in  1  ROM region select from execute
- io_access  in  1  current data access targets I/O; blocks new d grants
- fault  in  1  MMU fault; blocks new grants of either kind
- q_done  in  1  one-cycle pulse from QSPI: current line transfer complete
- q_req  out  1  transfer request to QSPI, held until q_done
- q_i_d  out  1  1 = transfer is for icache
- q_write  out  1  1 = line write (push)
- q_mem  out  1  ROM/RAM select latched at grant (rom_enable & !q_write)
- q_paddr  out  PA-LW  line tag latched at grant
- i_done  out  1  one-cycle pulse, icache refill complete
- d_done  out  1  one-cycle pulse, dcache push or pull complete
- busy  out  1  state != IDLE

## Operation
- States: IDLE, I_FILL, D_PUSH, D_PULL, GAP_WAIT.
- IDLE candidates: I = i_pull & !fault; D = (d_push | d_pull) & !fault & !io_access.
- Only one candidate: grant it. Both: grant the one not served last (last_d flag). last_d resets to 0, so the first contention goes to D.
- D grant: enter D_PUSH if d_push, else D_PULL. I grant: enter I_FILL. Set last_d on D grant, clear it on I grant.
- On grant, latch q_paddr (i_tag or d_tag), q_i_d, q_write (1 only in D_PUSH), and q_mem.
- D_PUSH + q_done: d_done pulse. If GAP>0, go to GAP_WAIT, otherwise go to D_PULL directly. After the gap, D_PULL re-latches d_tag, which the dcache has switched to the new tag. The icache cannot interleave between push and pull: a pull_pending flag bypasses arbitration.
- I_FILL or D_PULL + q_done: pulse i_done or d_done, then go to GAP_WAIT (or IDLE if GAP=0).
- GAP_WAIT: counter counts GAP-1 down to 0. At 0, go to D_PULL if pull_pending, else IDLE.
- fault or io_access rising mid-transfer does not abort; the transfer runs to q_done.
- q_done in IDLE or GAP_WAIT is ignored.

## Timing
- Reset values: q_req=0, q_i_d=0, q_write=0, q_mem=0, q_paddr=0, i_done=0, d_done=0, busy=0. State IDLE, last_d=0, pull_pending=0, counter=0.
- Request to q_req: 1 cycle. A request sampled high in IDLE at edge N gives q_req=1 after edge N+1, with tag and flags valid in the same cycle.
- q_req stays high through the cycle q_done is sampled and drops after that edge.
- i_done/d_done are registered and high for exactly the one cycle after the q_done edge.
- Gap: q_req is low for exactly GAP full cycles between transfers (GAP=0 allows back-to-back: q_req low for 1 cycle from the done transition).
- Requesters must hold pull/push until their done pulse. A requester that drops its line in IDLE before grant is simply not granted.
- reset asserted mid-transfer: immediate return to reset values. The QSPI is reset by the same net.

## Structure
- Shared package/include: state encodings (QA_IDLE..QA_GAP, 3 bits) and the LW derivation, also used by qspi and the caches.
- One sub-module is natural: qspi_arb_rr, a two-requester round-robin picker (inputs I, D, last_d; output grant_d, grant_any).
- The rest is a single FSM plus the gap counter in one file.

## Test plan
- i_pull alone, i_tag=0x12345, GAP=2, q_done 8 cycles after q_req -> q_req after 1 cycle, q_i_d=1, q_paddr=0x12345, i_done pulse, then q_req low for 2 cycles.
- d_push & d_pull, d_tag 0x00100 then switched to 0x00200 after d_done -> push with q_write=1 to 0x00100, gap, pull with q_write=0 to 0x00200. i_pull raised mid-push is not granted until after the pull.
- i_pull & d_pull asserted together repeatedly -> grants alternate D, I, D, I starting with D after reset.
- fault=1 with i_pull high -> no q_req. Release fault -> grant next cycle. io_access=1 blocks d_pull but not i_pull.
- reset driven 0 in the middle of D_PUSH -> all outputs 0 immediately. After release with no requests -> stays IDLE, and a stray q_done produces no done pulse.
- GAP=0, back-to-back i_pull -> q_req low exactly 1 cycle between transfers. rom_enable=1 on an icache fill -> q_mem=1. On a push, q_mem=0 regardless of rom_enable.
